// File: rtl/lsu_unit_if.sv
// rtl/lsu_unit_if.sv - data-memory request/ready bus between the LSU and memory
//
// Signals:
//   req    LSU -> mem  request, held until ready or timeout abort
//   we     LSU -> mem  write enable, stable while req
//   addr   LSU -> mem  word-aligned byte address
//   wdata  LSU -> mem  lane-replicated store data
//   wstrb  LSU -> mem  byte strobes, 0000 for loads
//   ready  mem -> LSU  accept/complete; rdata valid in the same cycle
//   rdata  mem -> LSU  read word
// Modports: master (LSU side), slave (memory side).

interface lsu_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit: one aligned data-memory transaction per start
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            launch request, sampled only in IDLE
//   is_store         1 = store, 0 = load (sampled with start)
//   funct3           RV32I load/store width/sign code (sampled with start)
//   addr             byte effective address (sampled with start)
//   wdata            store data (sampled with start)
//   busy             high whenever not IDLE
//   done             one-cycle completion pulse
//   fault            misaligned / illegal funct3 / timeout, valid with done
//   rdata_out        extended load result, valid with done, held until next done
//   mem              lsu_unit_if master port to data memory
// Parameter TIMEOUT: REQ cycles without ready before aborting; 0 disables.

module lsu_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata_out,
  lsu_unit_if.master  mem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        store_q, store_n;
  logic [2:0]  f3_q, f3_n;
  logic [1:0]  off_q, off_n;

  logic        busy_n, done_n, fault_n;
  logic [31:0] rdata_n;
  logic        req_n, we_n;
  logic [31:0] addr_n, wdata_n;
  logic [3:0]  wstrb_n;

  logic        f3_ok, aligned, legal;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [31:0] shifted, load_val;

  // Legality of the request presented with start.
  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !is_store;
      default:                f3_ok = 1'b0;
    endcase
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = !addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal = f3_ok && aligned;
  end

  // Store lane replication; memory picks the lane via the strobes.
  always_comb begin
    fmt_wdata = wdata;
    fmt_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{wdata[7:0]}};
        fmt_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{wdata[15:0]}};
        fmt_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        fmt_wdata = wdata;
        fmt_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane select and extension, using the offset latched at start.
  always_comb begin
    shifted  = mem.rdata >> {off_q, 3'b000};
    load_val = mem.rdata;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = mem.rdata;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    store_n = store_q;
    f3_n    = f3_q;
    off_n   = off_q;
    done_n  = 1'b0;
    fault_n = 1'b0;
    rdata_n = rdata_out;
    req_n   = mem.req;
    we_n    = mem.we;
    addr_n  = mem.addr;
    wdata_n = mem.wdata;
    wstrb_n = mem.wstrb;

    case (state)
      IDLE: begin
        if (start) begin
          store_n = is_store;
          f3_n    = funct3;
          off_n   = addr[1:0];
          if (legal) begin
            state_n = REQ;
            cnt_n   = 32'd0;
            req_n   = 1'b1;
            we_n    = is_store;
            addr_n  = {addr[31:2], 2'b00};
            wdata_n = fmt_wdata;
            wstrb_n = is_store ? fmt_wstrb : 4'b0000;
          end else begin
            state_n = RESP;
            done_n  = 1'b1;
            fault_n = 1'b1;
            rdata_n = 32'd0;
          end
        end
      end
      REQ: begin
        // ready is checked first so it wins over a simultaneous timeout.
        if (mem.ready) begin
          state_n = RESP;
          req_n   = 1'b0;
          we_n    = 1'b0;
          done_n  = 1'b1;
          rdata_n = store_q ? 32'd0 : load_val;
        end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
          // cnt counts earlier ready-less REQ cycles, so this is the TIMEOUT-th one.
          state_n = RESP;
          req_n   = 1'b0;
          we_n    = 1'b0;
          done_n  = 1'b1;
          fault_n = 1'b1;
          rdata_n = 32'd0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      store_q   <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata_out <= 32'd0;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= 32'd0;
      mem.wdata <= 32'd0;
      mem.wstrb <= 4'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      store_q   <= store_n;
      f3_q      <= f3_n;
      off_q     <= off_n;
      busy      <= busy_n;
      done      <= done_n;
      fault     <= fault_n;
      rdata_out <= rdata_n;
      mem.req   <= req_n;
      mem.we    <= we_n;
      mem.addr  <= addr_n;
      mem.wdata <= wdata_n;
      mem.wstrb <= wstrb_n;
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - scoreboard bench for lsu_unit with a delay-programmable memory responder

module tb_lsu_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata_out;

  lsu_unit_if mem ();

  lsu_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata_out (rdata_out),
    .mem       (mem)
  );

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          start_cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          mem_delay = 0;
  bit          mem_never = 0;
  logic [31:0] mem_data = 32'd0;
  int          req_k = 0;
  logic [31:0] last_rdata = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: ready rises in REQ cycle mem_delay+1; while no request is
  // pending ready is driven high so stray ready pulses are exercised throughout.
  initial begin
    mem.ready = 1'b0;
    mem.rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && mem.req) begin
        req_k++;
        if (req_k == 1) begin
          if (req_q.size() == 0) begin
            flag("unexpected_mem_req");
          end else begin
            req_t r;
            r = req_q.pop_front();
            chk("mem_we", {31'd0, mem.we}, {31'd0, r.we});
            chk("mem_addr", mem.addr, r.addr);
            chk("mem_wstrb", {28'd0, mem.wstrb}, {28'd0, r.wstrb});
            if (r.we) chk("mem_wdata", mem.wdata, r.wdata);
          end
        end
        mem.ready = !mem_never && (req_k == mem_delay + 1);
        mem.rdata = mem.ready ? mem_data : 32'h0BAD_0BAD;
      end else begin
        req_k = 0;
        mem.ready = rst_n;
        mem.rdata = 32'hDEAD_0000;
      end
    end
  end

  // Completion monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rdata = 32'd0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fault", {31'd0, fault}, {31'd0, e.fault});
          chk("rdata_out", rdata_out, e.rdata);
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("busy_at_done", {31'd0, busy}, 32'd1);
          last_rdata = e.rdata;
        end
      end else begin
        chk("rdata_hold", rdata_out, last_rdata);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) flag("idle_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      flag("done_timeout");
      exp_q.delete();
      req_q.delete();
    end
  endtask

  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int dly, input bit never,
                     input logic [31:0] md, input bit e_fault, input logic [31:0] e_rd,
                     input int lat, input bit has_req, input logic [31:0] e_addr,
                     input logic [31:0] e_wd, input logic [3:0] e_strb);
    exp_t e;
    req_t r;
    wait_idle();
    mem_delay = dly;
    mem_never = never;
    mem_data  = md;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    start     = 1'b1;
    e.fault = e_fault; e.rdata = e_rd; e.start_cyc = cyc; e.lat = lat;
    exp_q.push_back(e);
    if (has_req) begin
      r.we = st; r.addr = e_addr; r.wdata = e_wd; r.wstrb = e_strb;
      req_q.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    exp_t e;
    req_t r;
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    is_store = 1'b0;
    funct3 = 3'd0;
    addr = 32'd0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_req", {31'd0, mem.req}, 32'd0);
    chk("rst_we", {31'd0, mem.we}, 32'd0);
    chk("rst_addr", mem.addr, 32'd0);
    chk("rst_wdata", mem.wdata, 32'd0);
    chk("rst_wstrb", {28'd0, mem.wstrb}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    rst_n = 1'b1;

    //   st f3      addr          wdata         dly nvr mem_data      flt exp_rdata     lat req mem_addr      mem_wdata     strb
    run(0, 3'b000, 32'h0000_1003, 32'h0,        2,  0,  32'h80FF_1234, 0, 32'hFFFF_FF80, 4, 1, 32'h0000_1000, 32'h0,        4'b0000);
    run(1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 0, 0,  32'h0,        0, 32'h0,         2, 1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    run(0, 3'b010, 32'h0000_3001, 32'h0,        0,  0,  32'h0,        1, 32'h0,         1, 0, 32'h0,        32'h0,        4'b0000);
    run(0, 3'b011, 32'h0000_3000, 32'h0,        0,  0,  32'h0,        1, 32'h0,         1, 0, 32'h0,        32'h0,        4'b0000);
    run(0, 3'b010, 32'h0000_4000, 32'h0,        0,  1,  32'h0,        1, 32'h0,         5, 1, 32'h0000_4000, 32'h0,        4'b0000);
    run(0, 3'b010, 32'h0000_4004, 32'h0,        3,  0,  32'hCAFE_F00D, 0, 32'hCAFE_F00D, 5, 1, 32'h0000_4004, 32'h0,        4'b0000);
    run(1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 1, 0,  32'h0,        0, 32'h0,         3, 1, 32'h0000_5000, 32'hA5A5_A5A5, 4'b0010);
    run(0, 3'b001, 32'h0000_6002, 32'h0,        0,  0,  32'hF00D_1234, 0, 32'hFFFF_F00D, 2, 1, 32'h0000_6000, 32'h0,        4'b0000);
    run(1, 3'b100, 32'h0000_6000, 32'h1,        0,  0,  32'h0,        1, 32'h0,         1, 0, 32'h0,        32'h0,        4'b0000);
    run(0, 3'b100, 32'h0000_7002, 32'h0,        0,  0,  32'h11C3_2211, 0, 32'h0000_00C3, 2, 1, 32'h0000_7000, 32'h0,        4'b0000);
    run(1, 3'b001, 32'h0000_2001, 32'h1234,     0,  0,  32'h0,        1, 32'h0,         1, 0, 32'h0,        32'h0,        4'b0000);
    run(1, 3'b010, 32'h0000_8000, 32'h1234_5678, 2, 0,  32'h0,        0, 32'h0,         4, 1, 32'h0000_8000, 32'h1234_5678, 4'b1111);

    // Reset while in REQ: request and busy drop asynchronously, no done follows.
    wait_idle();
    mem_never = 1;
    is_store = 1'b0;
    funct3 = 3'b010;
    addr = 32'h0000_9000;
    start = 1'b1;
    r.we = 1'b0; r.addr = 32'h0000_9000; r.wdata = 32'h0; r.wstrb = 4'b0000;
    req_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("req_before_reset", {31'd0, mem.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, mem.req}, 32'd0);
    chk("async_busy_drop", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_never = 0;
    run(0, 3'b101, 32'h0000_0010, 32'h0, 0, 0, 32'h0000_8001, 0, 32'h0000_8001, 2, 1, 32'h0000_0010, 32'h0, 4'b0000);

    // start held high: relaunch only on each IDLE entry, ignored in REQ/RESP.
    wait_idle();
    mem_delay = 1;
    mem_never = 0;
    mem_data = 32'h1234_5678;
    is_store = 1'b0;
    funct3 = 3'b010;
    addr = 32'h0000_0040;
    c = cyc;
    start = 1'b1;
    e.fault = 1'b0; e.rdata = 32'h1234_5678; e.start_cyc = c; e.lat = 3;
    exp_q.push_back(e);
    e.start_cyc = c + 4;
    exp_q.push_back(e);
    r.we = 1'b0; r.addr = 32'h0000_0040; r.wdata = 32'h0; r.wstrb = 4'b0000;
    req_q.push_back(r);
    req_q.push_back(r);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);

    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
